// File: rtl/interrupt_controller.sv
// Interrupt entry sequencer: edge detect, drain, push return PC/flags, fetch handler vector, redirect fetch.
// Optional flag save is enabled by defining INTERRUPT_SAVE_FLAGS_EN.
module interrupt_controller #(
  parameter int          DRAIN_CYCLES = 3,
  parameter logic [15:0] VECTOR_ADDR  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        interrupt_signal,
  input  logic        branch_in_flight,
  input  logic [31:0] resume_pc,
  input  logic [2:0]  flags,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        stall_fetch,
  output logic        insert_nop,
  output logic        mem_req,
  output logic        mem_push,
  output logic        mem_read,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        pc_write,
  output logic [31:0] pc_value,
  output logic        busy,
  output logic        irq_taken,
  output logic [2:0]  state_dbg
);

  // Memory handshake: a request is held stable while mem_req=1 and completes
  // in the cycle mem_ack=1; mem_ack with mem_req=0 has no effect.
  typedef enum logic [2:0] {
    IDLE, DRAIN, PUSH_HI, PUSH_LO, PUSH_FLG, VEC_HI, VEC_LO, JUMP
  } state_t;

  state_t      state, state_nxt;
  logic        irq_d;
  logic        pending;
  logic [7:0]  drain_cnt;
  logic [31:0] ret_pc;
  logic        irq_edge;
  logic        accept;

`ifdef INTERRUPT_SAVE_FLAGS_EN
  logic [2:0]  flags_q;
`else
  logic        unused_flags;
  assign unused_flags = ^flags;
`endif

  assign irq_edge = interrupt_signal & ~irq_d;
  assign accept   = (state == IDLE) & pending & ~branch_in_flight;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      irq_d     <= 1'b0;
      pending   <= 1'b0;
      drain_cnt <= '0;
      ret_pc    <= '0;
      pc_value  <= '0;
      irq_taken <= 1'b0;
`ifdef INTERRUPT_SAVE_FLAGS_EN
      flags_q   <= '0;
`endif
    end else begin
      state     <= state_nxt;
      irq_d     <= interrupt_signal;
      irq_taken <= accept;
      // One-deep request latch: edges seen while already pending are dropped.
      if (accept)
        pending <= 1'b0;
      else if (irq_edge)
        pending <= 1'b1;
      if (accept) begin
        ret_pc    <= resume_pc;
        drain_cnt <= 8'(DRAIN_CYCLES - 1);
      end else if (state == DRAIN && drain_cnt != 8'd0) begin
        drain_cnt <= drain_cnt - 8'd1;
      end
`ifdef INTERRUPT_SAVE_FLAGS_EN
      if (state == DRAIN && drain_cnt == 8'd0)
        flags_q <= flags;
`endif
      if (mem_ack && state == VEC_HI)
        pc_value[31:16] <= mem_rdata;
      if (mem_ack && state == VEC_LO)
        pc_value[15:0] <= mem_rdata;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_push  = 1'b0;
    mem_read  = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 16'h0000;
    pc_write  = 1'b0;
    case (state)
      IDLE: begin
        if (accept)
          state_nxt = DRAIN;
      end
      DRAIN: begin
        if (drain_cnt == 8'd0)
          state_nxt = PUSH_HI;
      end
      PUSH_HI: begin
        mem_req   = 1'b1;
        mem_push  = 1'b1;
        mem_wdata = ret_pc[31:16];
        if (mem_ack)
          state_nxt = PUSH_LO;
      end
      PUSH_LO: begin
        mem_req   = 1'b1;
        mem_push  = 1'b1;
        mem_wdata = ret_pc[15:0];
        if (mem_ack) begin
`ifdef INTERRUPT_SAVE_FLAGS_EN
          state_nxt = PUSH_FLG;
`else
          state_nxt = VEC_HI;
`endif
        end
      end
      PUSH_FLG: begin
`ifdef INTERRUPT_SAVE_FLAGS_EN
        mem_req   = 1'b1;
        mem_push  = 1'b1;
        mem_wdata = {13'b0, flags_q};
        if (mem_ack)
          state_nxt = VEC_HI;
`else
        state_nxt = IDLE;
`endif
      end
      VEC_HI: begin
        mem_req  = 1'b1;
        mem_read = 1'b1;
        mem_addr = VECTOR_ADDR;
        if (mem_ack)
          state_nxt = VEC_LO;
      end
      VEC_LO: begin
        mem_req  = 1'b1;
        mem_read = 1'b1;
        mem_addr = VECTOR_ADDR + 16'd1;
        if (mem_ack)
          state_nxt = JUMP;
      end
      JUMP: begin
        pc_write  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Fetch is released in JUMP so it can load the handler address.
  assign busy        = (state != IDLE);
  assign insert_nop  = busy;
  assign stall_fetch = busy & (state != JUMP);
  assign state_dbg   = state;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: memory responder/scoreboard plus entry scenarios.
// Expected latencies adapt to whether INTERRUPT_SAVE_FLAGS_EN is defined.
module tb_interrupt_controller;

`ifdef INTERRUPT_SAVE_FLAGS_EN
  localparam int FLG = 1;
`else
  localparam int FLG = 0;
`endif
  localparam int DRAIN    = 3;
  // Cycles from the edge-sampling clock E0 to the cycle with pc_write high.
  localparam int BASE_LAT = 1 + DRAIN + 2 + FLG + 2;

  logic        clk, rst;
  logic        interrupt_signal, branch_in_flight;
  logic [31:0] resume_pc;
  logic [2:0]  flags;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        stall_fetch, insert_nop, mem_req, mem_push, mem_read;
  logic [15:0] mem_addr, mem_wdata;
  logic        pc_write;
  logic [31:0] pc_value;
  logic        busy, irq_taken;
  logic [2:0]  state_dbg;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [17:0] exp_q[$];
  logic [17:0] obs;
  int wait_idx, wait_left, req_idx, hold_cnt;
  int pw_count, pw_first, pw_last, it_count, it_cyc;
  logic [31:0] pw_val;
  logic [15:0] rd_hi, rd_lo;
  logic        spurious;
  int e0;

  interrupt_controller #(.DRAIN_CYCLES(DRAIN), .VECTOR_ADDR(16'h0000)) dut (
    .clk(clk), .rst(rst), .interrupt_signal(interrupt_signal),
    .branch_in_flight(branch_in_flight), .resume_pc(resume_pc), .flags(flags),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall_fetch(stall_fetch),
    .insert_nop(insert_nop), .mem_req(mem_req), .mem_push(mem_push),
    .mem_read(mem_read), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .pc_write(pc_write), .pc_value(pc_value), .busy(busy),
    .irq_taken(irq_taken), .state_dbg(state_dbg)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  // memory responder + scoreboard, runs on the falling edge
  always @(negedge clk) begin
    mem_ack   = 1'b0;
    mem_rdata = 16'h0000;
    if (!rst) begin
      if (pc_write) begin
        pw_count++;
        if (pw_count == 1) pw_first = cyc;
        pw_last = cyc;
        pw_val  = pc_value;
        check("jump_stall", {31'b0, stall_fetch}, 32'd0);
        check("jump_nop", {31'b0, insert_nop}, 32'd1);
      end
      if (irq_taken) begin
        it_count++;
        it_cyc = cyc;
      end
      if (mem_req) begin
        if (exp_q.size() == 0) begin
          check("unexpected_req", 32'(exp_q.size()), 32'd1);
        end else begin
          obs = {mem_push, mem_read, (mem_read ? mem_addr : mem_wdata)};
          check("mem_req", {14'b0, obs}, {14'b0, exp_q[0]});
          if (mem_push && mem_wdata == 16'h0042) hold_cnt++;
          if (req_idx == wait_idx && wait_left > 0) begin
            wait_left--;
          end else begin
            mem_ack = 1'b1;
            if (mem_read) mem_rdata = (mem_addr == 16'h0000) ? rd_hi : rd_lo;
            void'(exp_q.pop_front());
            req_idx++;
          end
        end
      end else if (spurious) begin
        mem_ack   = 1'b1;
        mem_rdata = 16'hFFFF;
      end
    end
  end

  task automatic clear_stats;
    pw_count = 0; it_count = 0; req_idx = 0; hold_cnt = 0;
    wait_left = 0; wait_idx = -1; pw_first = 0; pw_last = 0; it_cyc = 0;
    exp_q.delete();
  endtask

  task automatic load_entry(input logic [31:0] pc, input logic [2:0] f);
    exp_q.push_back({2'b10, pc[31:16]});
    exp_q.push_back({2'b10, pc[15:0]});
    if (FLG == 1) exp_q.push_back({2'b10, 13'b0, f});
    exp_q.push_back({2'b01, 16'h0000});
    exp_q.push_back({2'b01, 16'h0001});
  endtask

  // raise the request line; the next rising edge is E0
  task automatic pulse_irq(output int edge_cyc);
    interrupt_signal = 1'b1;
    edge_cyc = cyc + 1;
    tick;
    interrupt_signal = 1'b0;
  endtask

  task automatic wait_pw(input int n, input int budget);
    int k;
    k = 0;
    while (pw_count < n && k < budget) begin
      tick;
      k++;
    end
    check("pw_timeout", pw_count, n);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctrl"}, {24'b0, mem_req, mem_push, mem_read, pc_write, busy,
                           irq_taken, stall_fetch, insert_nop}, 32'd0);
    check({tag, "_pc"}, pc_value, 32'd0);
    check({tag, "_bus"}, {mem_addr, mem_wdata}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; interrupt_signal = 1'b0; branch_in_flight = 1'b0;
    resume_pc = '0; flags = '0; rd_hi = '0; rd_lo = '0; spurious = 1'b0;
    clear_stats;
    tick; tick;
    check_outputs_zero("reset");
    check("reset_state", {29'b0, state_dbg}, 32'd0);
    rst = 1'b0;
    tick;

    // basic entry
    clear_stats;
    resume_pc = 32'h0001_0042; flags = 3'b101; rd_hi = 16'h0000; rd_lo = 16'h0100;
    load_entry(32'h0001_0042, 3'b101);
    spurious = 1'b1;
    pulse_irq(e0);
    check("edge_not_yet_busy", {31'b0, busy}, 32'd0);
    tick;
    resume_pc = 32'hDEAD_BEEF;
    check("drain_ctrl", {29'b0, stall_fetch, insert_nop, mem_req}, 32'b110);
    wait_pw(1, 40);
    check("basic_lat", pw_first - e0, BASE_LAT);
    check("basic_pc", pw_val, 32'h0000_0100);
    check("basic_taken_lat", it_cyc - e0, 32'd1);
    check("basic_q_empty", 32'(exp_q.size()), 32'd0);
    tick;
    check("basic_idle", {31'b0, busy}, 32'd0);
    repeat (5) tick;
    check("basic_one_jump", pw_count, 32'd1);
    spurious = 1'b0;

    // wait states on PUSH_LO
    clear_stats;
    resume_pc = 32'h0001_0042; flags = 3'b011; rd_lo = 16'h0200;
    load_entry(32'h0001_0042, 3'b011);
    wait_idx = 1; wait_left = 2;
    pulse_irq(e0);
    wait_pw(1, 40);
    check("wait_lat", pw_first - e0, BASE_LAT + 2);
    check("wait_hold", hold_cnt, 32'd3);
    check("wait_pc", pw_val, 32'h0000_0200);
    repeat (3) tick;

    // blocked acceptance
    clear_stats;
    resume_pc = 32'h8000_1234; flags = 3'b010; rd_hi = 16'h0003; rd_lo = 16'h0004;
    load_entry(32'h8000_1234, 3'b010);
    branch_in_flight = 1'b1;
    pulse_irq(e0);
    check("blocked_busy0", {31'b0, busy}, 32'd0);
    while (cyc < e0 + 4) begin
      tick;
      check("blocked_busy", {31'b0, busy}, 32'd0);
    end
    branch_in_flight = 1'b0;
    wait_pw(1, 40);
    check("blocked_taken_lat", it_cyc - e0, 32'd5);
    check("blocked_lat", pw_first - e0, BASE_LAT + 4);
    check("blocked_pc", pw_val, 32'h0003_0004);
    check("blocked_taken_cnt", it_count, 32'd1);
    repeat (3) tick;

    // edges during busy: second pends, third dropped
    clear_stats;
    resume_pc = 32'h0000_0010; flags = 3'b001; rd_hi = 16'h0000; rd_lo = 16'h0040;
    load_entry(32'h0000_0010, 3'b001);
    load_entry(32'h0000_0010, 3'b001);
    pulse_irq(e0);
    while (cyc < e0 + 4) tick;
    interrupt_signal = 1'b1;
    tick;
    interrupt_signal = 1'b0;
    while (cyc < e0 + 6 + FLG) tick;
    interrupt_signal = 1'b1;
    tick;
    interrupt_signal = 1'b0;
    wait_pw(2, 60);
    check("nest_gap", pw_last - pw_first, BASE_LAT + 1);
    repeat (30) tick;
    check("nest_jumps", pw_count, 32'd2);
    check("nest_taken", it_count, 32'd2);
    check("nest_q_empty", 32'(exp_q.size()), 32'd0);

    // reset while in VEC_HI
    clear_stats;
    resume_pc = 32'h0000_0020; flags = 3'b100; rd_hi = 16'h1234; rd_lo = 16'h5678;
    load_entry(32'h0000_0020, 3'b100);
    pulse_irq(e0);
    while (cyc < e0 + 6 + FLG) tick;
    check("vec_hi_read", {15'b0, mem_read, mem_addr}, {15'b0, 1'b1, 16'h0000});
    rst = 1'b1;
    tick;
    check_outputs_zero("midrst");
    rst = 1'b0;
    exp_q.delete();
    repeat (20) tick;
    check("midrst_no_jump", pw_count, 32'd0);
    check("midrst_no_retake", it_count, 32'd1);
    check("midrst_idle", {31'b0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
